// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Package  : mips_pipe_pkg
// Desc     : Shared types and encodings for the pipeline hazard controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // EX/MEM wins over MEM/WB because it carries the younger result.
    function automatic logic [1:0] fwd_select(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] mem_dst,
        input logic             mem_rw,
        input logic [REG_W-1:0] wb_dst,
        input logic             wb_rw
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_rw && (mem_dst != '0) && (mem_dst == src))
            sel = FWD_EXMEM;
        else if (wb_rw && (wb_dst != '0) && (wb_dst == src))
            sel = FWD_MEMWB;
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_raw_detect.sv
// ============================================================================
// Module   : raw_detect
// Desc     : Flags a RAW dependency of the ID instruction on one producer stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module raw_detect
    import mips_pipe_pkg::*;
(
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_uses_rs,
    input  logic             i_uses_rt,
    input  logic [REG_W-1:0] i_dst,
    input  logic             i_regwrite,
    output logic             o_hit
);

    assign o_hit = i_regwrite && (i_dst != '0) &&
                   ((i_uses_rs && (i_dst == i_rs)) || (i_uses_rt && (i_dst == i_rt)));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Desc     : 5-stage pipeline enable/flush/forward control with post-reset fill
//            and data-memory wait freeze. Macro FORWARD_EN enables forwarding.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int INIT_BUBBLES = 2,
    parameter int STALL_CNT_W  = 16
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [REG_W-1:0]       ex_dst,
    input  logic                   ex_regwrite,
    input  logic                   ex_memread,
    input  logic [REG_W-1:0]       mem_dst,
    input  logic                   mem_regwrite,
    input  logic [REG_W-1:0]       wb_dst,
    input  logic                   wb_regwrite,
    input  logic                   ex_branch_taken,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   memwb_flush,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int c_init_w = (INIT_BUBBLES > 2) ? $clog2(INIT_BUBBLES) : 1;
    localparam logic [c_init_w-1:0] c_init_last =
        c_init_w'((INIT_BUBBLES > 0) ? INIT_BUBBLES - 1 : 0);

    pipe_state_t            r_state;
    logic [c_init_w-1:0]    r_init_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_ex_hit, w_mem_hit, w_wb_hit;
    logic                   w_raw_stall, w_freeze, w_unused;

    raw_detect u_raw_ex (
        .i_rs(id_rs), .i_rt(id_rt), .i_uses_rs(id_uses_rs), .i_uses_rt(id_uses_rt),
        .i_dst(ex_dst), .i_regwrite(ex_regwrite), .o_hit(w_ex_hit)
    );
    raw_detect u_raw_mem (
        .i_rs(id_rs), .i_rt(id_rt), .i_uses_rs(id_uses_rs), .i_uses_rt(id_uses_rt),
        .i_dst(mem_dst), .i_regwrite(mem_regwrite), .o_hit(w_mem_hit)
    );
    raw_detect u_raw_wb (
        .i_rs(id_rs), .i_rt(id_rt), .i_uses_rs(id_uses_rs), .i_uses_rt(id_uses_rt),
        .i_dst(wb_dst), .i_regwrite(wb_regwrite), .o_hit(w_wb_hit)
    );

`ifdef FORWARD_EN
    logic [REG_W-1:0] r_idex_rs, r_idex_rt;

    // Tracks the source registers held in ID/EX; a bubble keeps stale
    // indices, which is harmless since its control bits are zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idex_rs <= '0;
            r_idex_rt <= '0;
        end else if (idex_en) begin
            r_idex_rs <= id_rs;
            r_idex_rt <= id_rt;
        end
    end

    assign w_raw_stall = w_ex_hit && ex_memread;
    assign w_unused    = ^{w_mem_hit, w_wb_hit};
    assign fwd_a = reset ? FWD_RF : fwd_select(r_idex_rs, mem_dst, mem_regwrite, wb_dst, wb_regwrite);
    assign fwd_b = reset ? FWD_RF : fwd_select(r_idex_rt, mem_dst, mem_regwrite, wb_dst, wb_regwrite);
`else
    // No register-file bypass, so a WB producer must also be waited out.
    assign w_raw_stall = w_ex_hit || w_mem_hit || w_wb_hit;
    assign w_unused    = ex_memread;
    assign fwd_a       = FWD_RF;
    assign fwd_b       = FWD_RF;
`endif

    assign w_freeze = ((r_state == RUN) && dmem_req && !dmem_ready) ||
                      ((r_state == MEM_WAIT) && !dmem_ready);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (reset || (r_state == INIT)) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (w_freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (w_raw_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_init_cnt == c_init_last) begin
                        r_state    <= RUN;
                        r_init_cnt <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + c_init_w'(1);
                    end
                end
                RUN:      if (dmem_req && !dmem_ready) r_state <= MEM_WAIT;
                MEM_WAIT: if (dmem_ready) r_state <= RUN;
                default:  r_state <= INIT;
            endcase
            if (!pc_en && (r_state != INIT) && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Desc     : Directed self-checking bench for pipe_hazard_ctrl (either FORWARD_EN build).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;
    import mips_pipe_pkg::*;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk, reset;
    logic [4:0] id_rs, id_rt, ex_dst, mem_dst, wb_dst;
    logic       id_uses_rs, id_uses_rt, ex_regwrite, ex_memread;
    logic       mem_regwrite, wb_regwrite, ex_branch_taken, dmem_req, dmem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] exp_stall = 16'd0;

    pipe_hazard_ctrl #(.INIT_BUBBLES(2), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_dst(mem_dst), .mem_regwrite(mem_regwrite),
        .wb_dst(wb_dst), .wb_regwrite(wb_regwrite),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_dst = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_dst = 5'd0; mem_regwrite = 1'b0; wb_dst = 5'd0; wb_regwrite = 1'b0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        repeat (3) tick();
        #1;
        n_total++; if ({pc_en, ifid_en, idex_en, exmem_en} !== 4'b0001) $display("FAIL rst_enables got=%b exp=0001", {pc_en, ifid_en, idex_en, exmem_en}); else n_pass++;
        n_total++; if ({ifid_flush, idex_flush, memwb_flush} !== 3'b111) $display("FAIL rst_flushes got=%b exp=111", {ifid_flush, idex_flush, memwb_flush}); else n_pass++;
        n_total++; if ({fwd_a, fwd_b} !== 4'b0000 || stall_cnt !== 16'd0) $display("FAIL rst_fwd_cnt got=%b/%0d exp=0000/0", {fwd_a, fwd_b}, stall_cnt); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (pc_en !== 1'b0 || ifid_flush !== 1'b1) $display("FAIL init1 got pc_en=%b ifid_flush=%b exp 0/1", pc_en, ifid_flush); else n_pass++;
        tick();
        n_total++; if (pc_en !== 1'b0 || idex_flush !== 1'b1) $display("FAIL init2 got pc_en=%b idex_flush=%b exp 0/1", pc_en, idex_flush); else n_pass++;
        tick();
        n_total++; if (pc_en !== 1'b1 || {ifid_flush, idex_flush, memwb_flush} !== 3'b000) $display("FAIL run_start got pc_en=%b fl=%b exp 1/000", pc_en, {ifid_flush, idex_flush, memwb_flush}); else n_pass++;
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL init_cnt got=%0d exp=0", stall_cnt); else n_pass++;
    endtask

    task automatic test_load_use();
        tick(); idle();
        ex_dst = 5'd8; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_rs = 5'd8; id_uses_rs = 1'b1; id_rt = 5'd3; id_uses_rt = 1'b1;
        #1;
        n_total++; if ({pc_en, ifid_en, idex_flush, exmem_en} !== 4'b0011) $display("FAIL lu_stall got=%b exp=0011", {pc_en, ifid_en, idex_flush, exmem_en}); else n_pass++;
        // load now in MEM, bubble in EX
        tick(); ex_dst = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; mem_dst = 5'd8; mem_regwrite = 1'b1;
        #1;
        n_total++; if (pc_en !== FWD) $display("FAIL lu_mem_pc_en got=%b exp=%b", pc_en, FWD); else n_pass++;
        n_total++; if (fwd_a !== (FWD ? FWD_EXMEM : FWD_RF)) $display("FAIL lu_fwd_a got=%b exp=%b", fwd_a, FWD ? FWD_EXMEM : FWD_RF); else n_pass++;
        n_total++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); else n_pass++;
        tick(); mem_dst = 5'd0; mem_regwrite = 1'b0; wb_dst = 5'd8; wb_regwrite = 1'b1;
        #1;
        n_total++; if (pc_en !== FWD) $display("FAIL lu_wb_pc_en got=%b exp=%b", pc_en, FWD); else n_pass++;
        n_total++; if (fwd_a !== (FWD ? FWD_MEMWB : FWD_RF)) $display("FAIL lu_wb_fwd_a got=%b exp=%b", fwd_a, FWD ? FWD_MEMWB : FWD_RF); else n_pass++;
        tick(); idle();
        #1;
        n_total++; if (pc_en !== 1'b1) $display("FAIL lu_release got=%b exp=1", pc_en); else n_pass++;
        exp_stall = FWD ? 16'd1 : 16'd3;
        tick();
        n_total++; if (stall_cnt !== exp_stall) $display("FAIL lu_total_cnt got=%0d exp=%0d", stall_cnt, exp_stall); else n_pass++;
    endtask

    task automatic test_fwd_priority();
        idle(); id_rt = 5'd9;
        tick();
        mem_dst = 5'd9; mem_regwrite = 1'b1; wb_dst = 5'd9; wb_regwrite = 1'b1;
        #1;
        n_total++; if (fwd_b !== (FWD ? FWD_EXMEM : FWD_RF)) $display("FAIL fwd_b_both got=%b exp=%b", fwd_b, FWD ? FWD_EXMEM : FWD_RF); else n_pass++;
        n_total++; if (fwd_a !== FWD_RF || pc_en !== 1'b1) $display("FAIL fwd_a_none got=%b/%b exp=00/1", fwd_a, pc_en); else n_pass++;
        tick(); mem_regwrite = 1'b0; id_rt = 5'd0;
        #1;
        n_total++; if (fwd_b !== (FWD ? FWD_MEMWB : FWD_RF)) $display("FAIL fwd_b_wb got=%b exp=%b", fwd_b, FWD ? FWD_MEMWB : FWD_RF); else n_pass++;
        tick(); mem_dst = 5'd0; mem_regwrite = 1'b1; wb_dst = 5'd0; wb_regwrite = 1'b1;
        #1;
        n_total++; if (fwd_b !== FWD_RF) $display("FAIL fwd_b_r0 got=%b exp=00", fwd_b); else n_pass++;
    endtask

    task automatic test_mem_wait();
        tick(); idle(); dmem_req = 1'b1; ex_branch_taken = 1'b1;
        #1;
        n_total++; if ({pc_en, ifid_en, idex_en, exmem_en, memwb_flush} !== 5'b00001) $display("FAIL mw_first got=%b exp=00001", {pc_en, ifid_en, idex_en, exmem_en, memwb_flush}); else n_pass++;
        n_total++; if ({ifid_flush, idex_flush} !== 2'b00) $display("FAIL mw_branch_suppr got=%b exp=00", {ifid_flush, idex_flush}); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (dut.r_state !== MEM_WAIT || pc_en !== 1'b0 || memwb_flush !== 1'b1) $display("FAIL mw_hold%0d got st=%0d pc_en=%b mwf=%b exp 2/0/1", i, dut.r_state, pc_en, memwb_flush); else n_pass++;
        end
        tick(); dmem_ready = 1'b1;
        #1;
        n_total++; if ({pc_en, memwb_flush, ifid_flush, idex_flush} !== 4'b1011) $display("FAIL mw_done got=%b exp=1011", {pc_en, memwb_flush, ifid_flush, idex_flush}); else n_pass++;
        exp_stall = exp_stall + 16'd4;
        tick(); idle(); dmem_req = 1'b1; dmem_ready = 1'b1;
        #1;
        n_total++; if (stall_cnt !== exp_stall || dut.r_state !== RUN) $display("FAIL mw_cnt got=%0d st=%0d exp=%0d st=1", stall_cnt, dut.r_state, exp_stall); else n_pass++;
        n_total++; if (pc_en !== 1'b1 || memwb_flush !== 1'b0) $display("FAIL mw_ready_same got=%b/%b exp=1/0", pc_en, memwb_flush); else n_pass++;
        tick();
        n_total++; if (dut.r_state !== RUN || stall_cnt !== exp_stall) $display("FAIL mw_ready_state got st=%0d cnt=%0d exp 1/%0d", dut.r_state, stall_cnt, exp_stall); else n_pass++;
    endtask

    task automatic test_branch_raw();
        idle();
        ex_dst = 5'd8; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        n_total++; if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1111) $display("FAIL br_raw got=%b exp=1111", {pc_en, ifid_en, ifid_flush, idex_flush}); else n_pass++;
        tick(); idle();
        #1;
        n_total++; if (stall_cnt !== exp_stall) $display("FAIL br_cnt got=%0d exp=%0d", stall_cnt, exp_stall); else n_pass++;
    endtask

    task automatic test_wb_match();
        tick(); wb_dst = 5'd5; wb_regwrite = 1'b1; id_rs = 5'd5; id_uses_rs = 1'b1;
        #1;
        n_total++; if (pc_en !== FWD || fwd_a !== FWD_RF) $display("FAIL wb_match got pc_en=%b fwd_a=%b exp %b/00", pc_en, fwd_a, FWD); else n_pass++;
        tick(); idle();
        #1;
        n_total++; if (pc_en !== 1'b1) $display("FAIL wb_release got=%b exp=1", pc_en); else n_pass++;
        exp_stall = exp_stall + (FWD ? 16'd0 : 16'd1);
        tick();
        n_total++; if (stall_cnt !== exp_stall) $display("FAIL wb_cnt got=%0d exp=%0d", stall_cnt, exp_stall); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        idle(); dmem_req = 1'b1;
        tick();
        n_total++; if (dut.r_state !== MEM_WAIT) $display("FAIL rmw_enter got=%0d exp=2", dut.r_state); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if ({pc_en, exmem_en, ifid_flush} !== 3'b011) $display("FAIL rmw_outs got=%b exp=011", {pc_en, exmem_en, ifid_flush}); else n_pass++;
        tick();
        n_total++; if (dut.r_state !== INIT || stall_cnt !== 16'd0) $display("FAIL rmw_init got st=%0d cnt=%0d exp 0/0", dut.r_state, stall_cnt); else n_pass++;
        reset = 1'b0; idle();
        tick(); tick();
        n_total++; if (pc_en !== 1'b1 || stall_cnt !== 16'd0) $display("FAIL rmw_rerun got pc_en=%b cnt=%0d exp 1/0", pc_en, stall_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_mem_wait();
        test_branch_raw();
        test_wb_match();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
